// File: rtl/crack_controller.sv
// Search supervisor for a bank of key-cracker lanes: starts a search, times it,
// and captures the winning key for a ready/valid consumer.
module crack_controller #(
  parameter int KEY_W  = 32,
  parameter int NCRACK = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             success,
  input  logic [1:0]       successfulCracker,
  input  logic             exhausted,
  input  logic [KEY_W-1:0] candidate0,
  input  logic [KEY_W-1:0] candidate1,
  input  logic [KEY_W-1:0] candidate2,
  input  logic [KEY_W-1:0] candidate3,
  input  logic             keyReady,
  output logic             crackerEnable,
  output logic             crackerClear,
  output logic [KEY_W-1:0] keyOut,
  output logic [1:0]       crackerId,
  output logic             keyValid,
  output logic             notFound,
  output logic             busy,
  output logic [31:0]      cycleCount
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    REPORT,
    FAIL
  } state_t;

  state_t state;
  state_t stateNext;

  logic [KEY_W-1:0] candArr [NCRACK];

  logic             enableNext;
  logic             clearNext;
  logic [KEY_W-1:0] keyNext;
  logic [1:0]       idNext;
  logic             validNext;
  logic             notFoundNext;
  logic             busyNext;
  logic [31:0]      countNext;

  assign candArr[0] = candidate0;
  assign candArr[1] = candidate1;
  assign candArr[2] = candidate2;
  assign candArr[3] = candidate3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // success outranks exhausted; both only matter while the lanes are running
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start)              stateNext = CLEAR;
      CLEAR:                           stateNext = RUN;
      RUN: begin
        if (success)                   stateNext = REPORT;
        else if (exhausted)            stateNext = FAIL;
      end
      REPORT:  if (keyValid && keyReady) stateNext = IDLE;
      FAIL:    if (start)              stateNext = CLEAR;
      default:                         stateNext = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every one of them is a flop
  always_comb begin
    enableNext   = (stateNext == RUN);
    clearNext    = (stateNext == CLEAR);
    validNext    = (stateNext == REPORT);
    notFoundNext = (stateNext == FAIL);
    busyNext     = (stateNext == CLEAR) || (stateNext == RUN) || (stateNext == REPORT);
    keyNext      = keyOut;
    idNext       = crackerId;
    countNext    = cycleCount;
    if (state == RUN && success) begin
      keyNext = candArr[successfulCracker];
      idNext  = successfulCracker;
    end
    if (stateNext == CLEAR) begin
      countNext = '0;
    end else if (state == RUN && stateNext == RUN && cycleCount != 32'hFFFF_FFFF) begin
      countNext = cycleCount + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crackerEnable <= 1'b0;
      crackerClear  <= 1'b0;
      keyOut        <= '0;
      crackerId     <= '0;
      keyValid      <= 1'b0;
      notFound      <= 1'b0;
      busy          <= 1'b0;
      cycleCount    <= '0;
    end else begin
      crackerEnable <= enableNext;
      crackerClear  <= clearNext;
      keyOut        <= keyNext;
      crackerId     <= idNext;
      keyValid      <= validNext;
      notFound      <= notFoundNext;
      busy          <= busyNext;
      cycleCount    <= countNext;
    end
  end

endmodule

// File: tb/tb_crack_controller.sv
// Directed bench for crack_controller: search timing, capture, handshake,
// no-match path and asynchronous reset abandonment.
module tb_crack_controller;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        success;
  logic [1:0]  successfulCracker;
  logic        exhausted;
  logic [31:0] candidate0;
  logic [31:0] candidate1;
  logic [31:0] candidate2;
  logic [31:0] candidate3;
  logic        keyReady;
  logic        crackerEnable;
  logic        crackerClear;
  logic [31:0] keyOut;
  logic [1:0]  crackerId;
  logic        keyValid;
  logic        notFound;
  logic        busy;
  logic [31:0] cycleCount;

  int vectors;
  int miscompares;

  crack_controller #(.KEY_W(32), .NCRACK(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .success           (success),
    .successfulCracker (successfulCracker),
    .exhausted         (exhausted),
    .candidate0        (candidate0),
    .candidate1        (candidate1),
    .candidate2        (candidate2),
    .candidate3        (candidate3),
    .keyReady          (keyReady),
    .crackerEnable     (crackerEnable),
    .crackerClear      (crackerClear),
    .keyOut            (keyOut),
    .crackerId         (crackerId),
    .keyValid          (keyValid),
    .notFound          (notFound),
    .busy              (busy),
    .cycleCount        (cycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic suc, input logic [1:0] idx,
                               input logic exh, input logic rdy);
    start             = st;
    success           = suc;
    successfulCracker = idx;
    exhausted         = exh;
    keyReady          = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    candidate0  = 32'h0000_1111;
    candidate1  = 32'h0000_2222;
    candidate2  = 32'hDEAD_BEEF;
    candidate3  = 32'h0000_4444;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // reset state
    repeat (2) tick();
    checkOutput("rst_enable", crackerEnable, 0);
    checkOutput("rst_clear", crackerClear, 0);
    checkOutput("rst_keyOut", keyOut, 0);
    checkOutput("rst_id", crackerId, 0);
    checkOutput("rst_valid", keyValid, 0);
    checkOutput("rst_notFound", notFound, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", cycleCount, 0);

    resetn = 1'b1;
    repeat (2) tick();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_enable", crackerEnable, 0);

    // search 1: match on lane 2 after 10 run cycles
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("s1_clear", crackerClear, 1);
    checkOutput("s1_clear_busy", busy, 1);
    checkOutput("s1_clear_en", crackerEnable, 0);
    checkOutput("s1_clear_count", cycleCount, 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("s1_clear_drop", crackerClear, 0);
    checkOutput("s1_run_en", crackerEnable, 1);
    checkOutput("s1_run_busy", busy, 1);
    repeat (10) tick();
    checkOutput("s1_count10", cycleCount, 10);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    checkOutput("s1_keyOut", keyOut, 32'hDEAD_BEEF);
    checkOutput("s1_id", crackerId, 2);
    checkOutput("s1_valid", keyValid, 1);
    checkOutput("s1_en_off", crackerEnable, 0);
    checkOutput("s1_count_hold", cycleCount, 10);
    checkOutput("s1_report_busy", busy, 1);

    // consumer stalls; start/success during REPORT must not disturb the capture
    candidate2 = 32'h5555_AAAA;
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("s1_hold_valid", keyValid, 1);
      checkOutput("s1_hold_key", keyOut, 32'hDEAD_BEEF);
      checkOutput("s1_hold_id", crackerId, 2);
      checkOutput("s1_hold_clear", crackerClear, 0);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("s1_done_valid", keyValid, 0);
    checkOutput("s1_done_busy", busy, 0);
    checkOutput("s1_retain_key", keyOut, 32'hDEAD_BEEF);
    checkOutput("s1_retain_id", crackerId, 2);

    // search 2: start ignored mid-run, success and exhausted together, early keyReady
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("s2_clear", crackerClear, 1);
    checkOutput("s2_key_kept", keyOut, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("s2_run_en", crackerEnable, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("s2_start_ignored", crackerClear, 0);
    checkOutput("s2_count1", cycleCount, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("s2_count3", cycleCount, 3);
    candidate1 = 32'h1234_5678;
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    tick();
    checkOutput("s2_valid", keyValid, 1);
    checkOutput("s2_notFound", notFound, 0);
    checkOutput("s2_keyOut", keyOut, 32'h1234_5678);
    checkOutput("s2_id", crackerId, 1);
    checkOutput("s2_count_hold", cycleCount, 3);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("s2_done_valid", keyValid, 0);
    checkOutput("s2_done_busy", busy, 0);

    // search 3: exhausted ignored in IDLE, then no-match path and restart from FAIL
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    checkOutput("s3_idle_exh", notFound, 0);
    checkOutput("s3_idle_suc", keyValid, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("s3_count1", cycleCount, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    checkOutput("s3_notFound", notFound, 1);
    checkOutput("s3_en_off", crackerEnable, 0);
    checkOutput("s3_count_hold", cycleCount, 1);
    checkOutput("s3_fail_busy", busy, 0);
    checkOutput("s3_fail_valid", keyValid, 0);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    checkOutput("s3_notFound_hold", notFound, 1);
    checkOutput("s3_fail_suc_ignored", keyValid, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("s3_restart_nf", notFound, 0);
    checkOutput("s3_restart_clear", crackerClear, 1);
    checkOutput("s3_restart_count", cycleCount, 0);

    // reset between clock edges mid-run abandons the search
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("s4_run_en", crackerEnable, 1);
    checkOutput("s4_count2", cycleCount, 2);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("s4_rst_en", crackerEnable, 0);
    checkOutput("s4_rst_count", cycleCount, 0);
    checkOutput("s4_rst_busy", busy, 0);
    checkOutput("s4_rst_key", keyOut, 0);
    tick();
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("s4_post_valid", keyValid, 0);
    checkOutput("s4_post_busy", busy, 0);
    checkOutput("s4_post_key", keyOut, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crack_controller.md
CRACK_CONTROLLER -- requirements
Module: crack_controller

Interface
REQ-001 Parameter KEY_W, default 32, width of each candidate key.
REQ-002 Parameter NCRACK, fixed 4, number of cracker lanes; candidate inputs SHALL be one port per lane.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a new search; sampled high in IDLE or FAIL only.
REQ-006 success  input  1  found flag from the success detector.
REQ-007 successfulCracker  input  2  index of the winning lane; valid only when success=1.
REQ-008 exhausted  input  1  all lanes have finished their keyspace.
REQ-009 candidate0..candidate3  input  KEY_W each  current key of lanes 0-3, aligned with success.
REQ-010 keyReady  input  1  consumer accepts keyOut.
REQ-011 crackerEnable  output  1  run enable to all lanes.
REQ-012 crackerClear  output  1  one-cycle reload pulse to all lanes.
REQ-013 keyOut  output  KEY_W  captured winning key.
REQ-014 crackerId  output  2  captured winning lane index.
REQ-015 keyValid  output  1  keyOut/crackerId valid.
REQ-016 notFound  output  1  search ended without a match.
REQ-017 busy  output  1  high in CLEAR, RUN and REPORT.
REQ-018 cycleCount  output  32  number of RUN cycles in the current or last search.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, RUN, REPORT and FAIL, and all outputs SHALL be registered.
REQ-020 IDLE: crackerEnable=0; start=1 -> CLEAR.
REQ-021 CLEAR: lasts exactly one cycle with crackerClear=1 and cycleCount reset to 0, then -> RUN.
REQ-022 RUN: crackerEnable=1; cycleCount SHALL increment by 1 per cycle, saturating at 0xFFFFFFFF without wrap.
REQ-023 RUN with success=1 at edge k: on that same edge, keyOut SHALL load the candidate selected by successfulCracker, crackerId SHALL load successfulCracker, keyValid SHALL go to 1, crackerEnable SHALL go to 0, cycleCount SHALL hold, and the FSM SHALL go -> REPORT.
REQ-024 RUN with exhausted=1 and success=0: notFound=1, crackerEnable=0, cycleCount held, FSM -> FAIL.
REQ-025 When success and exhausted are high in the same cycle, success SHALL win.
REQ-026 success and exhausted SHALL be ignored in every state except RUN.
REQ-027 REPORT: keyValid, keyOut and crackerId SHALL stay stable until a cycle with keyValid=1 and keyReady=1; on that edge keyValid=0 and FSM -> IDLE; keyOut and crackerId SHALL retain their values.
REQ-028 keyReady SHALL be allowed high before keyValid; the transfer SHALL complete on the first cycle both are high.
REQ-029 start SHALL be ignored in CLEAR, RUN and REPORT.
REQ-030 FAIL: notFound holds 1; start=1 -> CLEAR, and notFound SHALL clear on that edge.
REQ-031 A start in IDLE SHALL NOT alter keyOut or crackerId until the next capture.

Reset
REQ-032 resetn=0 SHALL force IDLE immediately, independent of clk.
REQ-033 While resetn=0, all outputs SHALL be 0: crackerEnable, crackerClear, keyValid, notFound, busy, keyOut, crackerId and cycleCount.
REQ-034 Reset asserted mid-RUN or mid-REPORT SHALL abandon the search, and no key SHALL be reported afterward.
REQ-035 After resetn rises, the block SHALL stay in IDLE until the first start.

Verification
REQ-036 Reset, then start pulse -> crackerClear=1 for exactly 1 cycle, then crackerEnable=1 and busy=1.
REQ-037 RUN 10 cycles, then success=1 with successfulCracker=2'b10 and candidate2=32'hDEADBEEF -> keyOut=32'hDEADBEEF, crackerId=2, keyValid=1, crackerEnable=0 and cycleCount=10, all after the same edge.
REQ-038 keyReady held 0 for 5 cycles, then 1 -> keyValid stays 1 and keyOut stays stable for 5 cycles, then keyValid=0 and FSM in IDLE one cycle after keyReady rises.
REQ-039 success=1 and exhausted=1 in the same RUN cycle -> REPORT with keyValid=1 and notFound=0.
REQ-040 exhausted=1 with no match -> notFound=1; a following start -> notFound=0 and crackerClear=1.
REQ-041 resetn=0 between clock edges mid-RUN -> crackerEnable and cycleCount are 0 immediately, and success afterward does not set keyValid.
